msk_inv_sbox_lin_pipe: RTL and testbench
========================================

Name: msk_inv_sbox_lin_pipe

Overview:
- Masked, bitsliced linear layer placed in front of the Clyde S-box datapath, so the direct S-box can also serve the inverse S-box during decryption.
- Extends the single-bit, combinational pre-inverse mapping to:
  - COUNT bit positions per bitslice;
  - three run-time modes: bypass, forward pre-inverse, reverse;
  - a registered 2-entry elastic buffer with valid/ready handshakes.
- All operations are share-wise. Output share k depends only on input share k, so the block is d-share safe by construction.

Parameters:
- d, 4, number of shares per masked bit (>=1).
- COUNT, 32, bits per bitslice (S-boxes processed in parallel, >=1).
- W, 4*COUNT*d, derived bus width; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W  masked state. Share s of bit j of slice i sits at [((i*COUNT)+j)*d + s].
- in_mode  in  2  transform selector: 0 bypass, 1 forward, 2 reverse, 3 illegal. Sampled together with in_data.
- in_valid  in  1  in_data/in_mode are valid.
- in_ready  out  1  block can accept data this cycle.
- out_data  out  W  transformed masked state, same packing as in_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- err_mode  out  1  sticky flag: an illegal mode was accepted.

Behaviour:
- Slices x0..x3 are each COUNT*d wide; "^" is share-wise XOR.
- Transform per mode:
  - Mode 0 (bypass): y0=x0, y1=x1, y2=x2, y3=x3.
  - Mode 1 (forward): y0=x1, y1=x0^x2, y2=x3, y3=x0.
  - Mode 2 (reverse, exact inverse of mode 1): y0=x3, y1=x0, y2=x1^x3, y3=x2.
  - Mode 3: data is transformed as bypass and err_mode is set to 1.
- The transform is applied combinationally at the input. Only the transformed result is stored; the mode is not stored.
- Storage: a 2-entry buffer with a head register (drives out_data) and a skid register.
  - Count 0..2. The count is held in registers, not derived combinationally from out_ready.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = (count < 2).
  - out_valid = (count > 0).
  - Data is ordered strictly FIFO.
- Latency and throughput:
  - Data accepted into an empty buffer appears on out_data with out_valid=1 the next cycle (latency 1).
  - Sustained throughput is 1 word/cycle when out_ready is held at 1.
- Simultaneous events:
  - Push and pop in the same cycle leave count unchanged. Head takes skid if count was 2, otherwise head takes the new word.
  - Push while count=2 cannot occur, because in_ready=0.
  - Pop while count=0 is ignored.
- Stall: while out_valid=1 and out_ready=0, out_data holds stable and does not glitch.
- Reset (asynchronous assert, at any time, including mid-transfer):
  - count=0, out_valid=0, in_ready=1 after release.
  - Head and skid cleared to all zeros.
  - err_mode=0.
  - Any in-flight data is discarded.
- err_mode is set only on an accepted word with mode 3. It is cleared only by rst.
- Masking rules:
  - No gate may combine bits of different share indices.
  - Head and skid outputs are direct register outputs.
  - The skid-to-head mux is per-share.

Test Plan:
- Forward, d=2, COUNT=1: push {x3,x2,x1,x0}={00,01,11,10}, mode 1, out_ready=1 → next cycle out_valid=1, out_data {y3,y2,y1,y0}={10,00,11,11}.
- Reverse round trip: push that result {10,00,11,11} with mode 2 → out_data={00,01,11,10}. Random 1000-vector sweep at d=4, COUNT=32: mode 2 of mode 1 output equals the input; unmasked XOR of shares matches a golden model.
- Backpressure: out_ready=0, push A then B → in_ready drops to 0 after the 2nd push. Raise out_ready → A then B delivered in order. out_data held stable while stalled.
- Simultaneous push/pop at count=1 for 16 back-to-back words → one word per cycle, in order, no bubbles.
- Illegal mode: push with mode 3 → out_data equals input (bypass), err_mode=1 and stays set after subsequent legal pushes, until rst.
- Mid-operation reset: count=2, assert rst asynchronously between edges → out_valid=0 and err_mode=0 immediately. After release in_ready=1 and no stale word emerges.

Source files
------------

// File: rtl/msk_inv_sbox_lin_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : msk_inv_sbox_lin_pipe
//  Description : Masked, bitsliced linear layer in front of the Clyde S-box.
//                Applies bypass / forward pre-inverse / reverse mapping to the
//                four slices share-wise, then stores the result in a 2-entry
//                elastic buffer (head + skid) with valid/ready handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module msk_inv_sbox_lin_pipe #(
    parameter  int d     = 4,
    parameter  int COUNT = 32,
    localparam int W     = 4 * COUNT * d
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err_mode
);

    // One slice holds COUNT bits, each carried as d shares.
    localparam int SW = COUNT * d;

    localparam logic [1:0] MODE_BYPASS  = 2'd0;
    localparam logic [1:0] MODE_FORWARD = 2'd1;
    localparam logic [1:0] MODE_REVERSE = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    // Buffer occupancy doubles as the control state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [SW-1:0] w_x0, w_x1, w_x2, w_x3;
    logic [SW-1:0] w_y0, w_y1, w_y2, w_y3;
    logic [W-1:0]  w_xf;

    logic [1:0]    r_count;
    logic [1:0]    w_count_nxt;
    logic [W-1:0]  r_head;
    logic [W-1:0]  r_skid;
    logic          r_err;

    logic          w_push;
    logic          w_pop;
    logic          w_head_load;
    logic          w_head_from_skid;
    logic          w_skid_load;

    assign w_x0 = in_data[0*SW +: SW];
    assign w_x1 = in_data[1*SW +: SW];
    assign w_x2 = in_data[2*SW +: SW];
    assign w_x3 = in_data[3*SW +: SW];

    // Slice permutation/XOR; slices share identical share packing, so a
    // vector XOR of two slices only ever combines equal share indices.
    always_comb begin
        w_y0 = w_x0;
        w_y1 = w_x1;
        w_y2 = w_x2;
        w_y3 = w_x3;
        case (in_mode)
            MODE_FORWARD: begin
                w_y0 = w_x1;
                w_y1 = w_x0 ^ w_x2;
                w_y2 = w_x3;
                w_y3 = w_x0;
            end
            MODE_REVERSE: begin
                w_y0 = w_x3;
                w_y1 = w_x0;
                w_y2 = w_x1 ^ w_x3;
                w_y3 = w_x2;
            end
            default: begin
                // Bypass, and the illegal mode is also passed through unchanged.
                w_y0 = w_x0;
                w_y1 = w_x1;
                w_y2 = w_x2;
                w_y3 = w_x3;
            end
        endcase
    end

    assign w_xf   = {w_y3, w_y2, w_y1, w_y0};
    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= ST_EMPTY;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Next occupancy plus load strobes for head and skid.
    always_comb begin
        w_count_nxt      = r_count;
        w_head_load      = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_count)
            ST_EMPTY: begin
                if (w_push) begin
                    w_head_load = 1'b1;
                    w_count_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_head_load = 1'b1;
                end else if (w_push) begin
                    w_skid_load = 1'b1;
                    w_count_nxt = ST_FULL;
                end else if (w_pop) begin
                    w_count_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_head_load      = 1'b1;
                    w_head_from_skid = 1'b1;
                    w_count_nxt      = ST_ONE;
                end
            end
            default: begin
                w_count_nxt = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs decoded purely from registered occupancy.
    always_comb begin
        in_ready  = (r_count == ST_EMPTY) || (r_count == ST_ONE);
        out_valid = (r_count == ST_ONE)   || (r_count == ST_FULL);
    end

    // Head/skid storage; the head holds its value whenever it is not loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_load) begin
                r_head <= w_head_from_skid ? r_skid : w_xf;
            end
            if (w_skid_load) begin
                r_skid <= w_xf;
            end
        end
    end

    // Sticky illegal-mode flag, set only by an accepted mode-3 word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_push && (in_mode == MODE_ILLEGAL)) begin
            r_err <= 1'b1;
        end
    end

    assign out_data = r_head;
    assign err_mode = r_err;

endmodule
`default_nettype wire

// File: tb/tb_msk_inv_sbox_lin_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msk_inv_sbox_lin_pipe
//  Description : Self-checking bench for msk_inv_sbox_lin_pipe. A queue-based
//                reference model predicts handshakes, data order and values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msk_inv_sbox_lin_pipe;

    localparam int D  = 4;
    localparam int C  = 32;
    localparam int WW = 4 * C * D;
    localparam int UW = 4 * C;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [WW-1:0]   in_data = '0;
    logic [1:0]      in_mode = 2'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            err_mode;

    logic [7:0]      s_in_data = '0;
    logic [1:0]      s_in_mode = 2'd0;
    logic            s_in_valid = 1'b0;
    logic            s_in_ready;
    logic [7:0]      s_out_data;
    logic            s_out_valid;
    logic            s_out_ready = 1'b0;
    logic            s_err_mode;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0] q_exp  [$];
    logic [UW-1:0] q_uexp [$];
    logic          err_m = 1'b0;
    int            n_push = 0;

    always #5 clk = ~clk;

    msk_inv_sbox_lin_pipe #(.d(D), .COUNT(C)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err_mode(err_mode)
    );

    msk_inv_sbox_lin_pipe #(.d(2), .COUNT(1)) dut_small (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_mode(s_in_mode),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .err_mode(s_err_mode)
    );

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Share-level reference: bit (slice i, position j, share s).
    function automatic int idx(input int i, input int j, input int s);
        return (i * C + j) * D + s;
    endfunction

    function automatic logic [WW-1:0] ref_xform(input logic [WW-1:0] x, input logic [1:0] mode);
        logic [WW-1:0] y;
        logic b0, b1, b2, b3;
        y = x;
        for (int j = 0; j < C; j++) begin
            for (int s = 0; s < D; s++) begin
                b0 = x[idx(0, j, s)]; b1 = x[idx(1, j, s)];
                b2 = x[idx(2, j, s)]; b3 = x[idx(3, j, s)];
                if (mode == 2'd1) begin
                    y[idx(0, j, s)] = b1;      y[idx(1, j, s)] = b0 ^ b2;
                    y[idx(2, j, s)] = b3;      y[idx(3, j, s)] = b0;
                end else if (mode == 2'd2) begin
                    y[idx(0, j, s)] = b3;      y[idx(1, j, s)] = b0;
                    y[idx(2, j, s)] = b1 ^ b3; y[idx(3, j, s)] = b2;
                end
            end
        end
        return y;
    endfunction

    // Recombine shares into the plain bitsliced value.
    function automatic logic [UW-1:0] unmask(input logic [WW-1:0] x);
        logic [UW-1:0] u;
        for (int k = 0; k < UW; k++) u[k] = ^x[k*D +: D];
        return u;
    endfunction

    // Plain (unmasked) golden model on four COUNT-bit words.
    function automatic logic [UW-1:0] ref_plain(input logic [UW-1:0] u, input logic [1:0] mode);
        logic [C-1:0] a0, a1, a2, a3;
        a0 = u[0 +: C]; a1 = u[C +: C]; a2 = u[2*C +: C]; a3 = u[3*C +: C];
        case (mode)
            2'd1:    return {a0, a3, a0 ^ a2, a1};
            2'd2:    return {a2, a1 ^ a3, a0, a3};
            default: return u;
        endcase
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int k = 0; k < WW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic pm, qm;
        @(negedge clk);
        check("out_valid", {511'd0, out_valid}, {511'd0, q_exp.size() > 0});
        check("in_ready", {511'd0, in_ready}, {511'd0, q_exp.size() < 2});
        check("err_mode", {511'd0, err_mode}, {511'd0, err_m});
        if (q_exp.size() > 0) begin
            check("out_data", out_data, q_exp[0]);
            check("unmasked", {384'd0, unmask(out_data)}, {384'd0, q_uexp[0]});
        end
        pm = in_valid && (q_exp.size() < 2);
        qm = out_ready && (q_exp.size() > 0);
        @(posedge clk);
        #1;
        if (qm) begin
            void'(q_exp.pop_front());
            void'(q_uexp.pop_front());
        end
        if (pm) begin
            q_exp.push_back(ref_xform(in_data, in_mode));
            q_uexp.push_back(ref_plain(unmask(in_data), in_mode));
            if (in_mode == 2'd3) err_m = 1'b1;
            n_push++;
        end
    endtask

    initial begin
        logic [WW-1:0] a, b, x, y, held;
        int cyc;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", {511'd0, out_valid}, '0);
        check("rst_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});
        check("rst_err", {511'd0, err_mode}, '0);
        check("rst_out_data", out_data, '0);
        @(posedge clk); #1 rst = 1'b0;

        // ---------------- small instance: forward then reverse ----------------
        s_in_data = 8'b00_01_11_10; s_in_mode = 2'd1; s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("small_fwd_valid", {511'd0, s_out_valid}, {511'd0, 1'b1});
        check("small_fwd_data", {504'd0, s_out_data}, {504'd0, 8'b10_00_11_11});
        s_in_data = 8'b10_00_11_11; s_in_mode = 2'd2; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("small_rev_data", {504'd0, s_out_data}, {504'd0, 8'b00_01_11_10});
        @(posedge clk); #1;
        check("small_drained", {511'd0, s_out_valid}, '0);
        check("small_err", {511'd0, s_err_mode}, '0);

        // ---------------- random sweep, random handshakes ----------------
        n_push = 0;
        cyc = 0;
        while (n_push < 1000 && cyc < 5000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 2));
            in_data   = rand_word();
            cycle();
            cyc++;
        end
        check("sweep_budget", {511'd0, n_push >= 1000}, {511'd0, 1'b1});
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // ---------------- round trip: reverse(forward(x)) == x ----------------
        for (int r = 0; r < 20; r++) begin
            x = rand_word();
            in_data = x; in_mode = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            y = out_data;
            in_data = y; in_mode = 2'd2;
            cycle();
            in_valid = 1'b0;
            check("roundtrip", out_data, x);
            cycle();
        end

        // ---------------- backpressure and stall ----------------
        a = rand_word(); b = rand_word();
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1;
        in_data = a; cycle();
        in_data = b; cycle();
        in_valid = 1'b0;
        check("bp_in_ready_low", {511'd0, in_ready}, '0);
        held = out_data;
        cycle(); cycle();
        check("bp_stall_stable", out_data, held);
        check("bp_head_is_a", out_data, ref_xform(a, 2'd1));
        out_ready = 1'b1;
        cycle();
        check("bp_then_b", out_data, ref_xform(b, 2'd1));
        cycle(); cycle();

        // ---------------- simultaneous push/pop, 16 words back-to-back ----------------
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'd2;
        in_data = rand_word(); cycle();
        for (int k = 0; k < 16; k++) begin
            in_data = rand_word(); in_mode = 2'($urandom_range(0, 2));
            cycle();
            check("b2b_no_bubble", {511'd0, out_valid}, {511'd0, 1'b1});
        end
        in_valid = 1'b0;
        cycle(); cycle();

        // ---------------- illegal mode ----------------
        x = rand_word();
        in_data = x; in_mode = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("illegal_bypass", out_data, x);
        check("illegal_err", {511'd0, err_mode}, {511'd0, 1'b1});
        in_valid = 1'b1; in_mode = 2'd1;
        for (int k = 0; k < 4; k++) begin
            in_data = rand_word(); cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("err_sticky", {511'd0, err_mode}, {511'd0, 1'b1});

        // ---------------- asynchronous reset with a full buffer ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0;
        in_data = rand_word(); cycle();
        in_data = rand_word(); cycle();
        in_valid = 1'b0;
        check("pre_rst_full", {511'd0, in_ready}, '0);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", {511'd0, out_valid}, '0);
        check("async_err", {511'd0, err_mode}, '0);
        check("async_out_data", out_data, '0);
        @(posedge clk); #1 rst = 1'b0;
        q_exp.delete(); q_uexp.delete(); err_m = 1'b0;
        out_ready = 1'b1;
        check("post_rst_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});
        for (int k = 0; k < 4; k++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
